// File: rtl/eth_pkg.sv
// eth_pkg: shared state encoding and Ethernet framing constants for the TX scheduler
package eth_pkg;
    typedef enum logic [2:0] {IDLE, START, PAYLOAD, PAD, DRAIN, WAIT_DONE, IFG} state_t;
    localparam int MIN_PAYLOAD_BYTES = 46;
    localparam int MAX_PAYLOAD_BYTES = 1500;
    localparam int IFG_BITS = 96;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the lowest requester at or after ptr
//   req  in  NREQ  request vector
//   ptr  in  3     first index with priority
//   gnt  out NREQ  one-hot grant (all zero when nothing requests)
//   idx  out 3     index of the granted requester
module rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    output logic [NREQ-1:0] gnt,
    output logic [2:0]      idx
);
    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] hi;
    logic [NREQ-1:0] pick;

    assign hi   = req & mask;
    // Requests at or above ptr win; otherwise wrap to the lowest requester.
    assign pick = (|hi) ? hi : req;

    always_comb begin
        mask = '0;
        for (int i = 0; i < NREQ; i++) mask[i] = 3'(i) >= ptr;
    end

    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pick[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                idx    = 3'(i);
            end
        end
    end
endmodule

// File: rtl/eth_tx_scheduler.sv
// eth_tx_scheduler: round-robin sharing of the Ethernet TX datapath among NREQ frame sources
//   clk, rst(async active-low)
//   req_valid/req_data/req_last/req_dest_mac/req_etype in, req_ready out : per-requester payload streams
//   grant_id, tx_start, tx_dest_mac, tx_etype out                         : frame start and header fields
//   tx_valid/tx_data/tx_last out, tx_ready in                             : payload beats to the datapath
//   tx_busy in                                                            : datapath still on the wire
//   trunc_err, frames_sent out                                            : status
module eth_tx_scheduler
    import eth_pkg::*;
#(
    parameter int N    = 2,
    parameter int NREQ = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*N-1:0]    req_data,
    input  logic [NREQ-1:0]      req_last,
    input  logic [NREQ*48-1:0]   req_dest_mac,
    input  logic [NREQ*16-1:0]   req_etype,
    output logic [NREQ-1:0]      req_ready,
    output logic [2:0]           grant_id,
    output logic                 tx_start,
    output logic [47:0]          tx_dest_mac,
    output logic [15:0]          tx_etype,
    input  logic                 tx_ready,
    output logic                 tx_valid,
    output logic [N-1:0]         tx_data,
    output logic                 tx_last,
    input  logic                 tx_busy,
    output logic                 trunc_err,
    output logic [15:0]          frames_sent
);
    localparam logic [13:0] MIN_BEATS  = 14'(MIN_PAYLOAD_BYTES * 8 / N);
    localparam logic [13:0] MAX_BEATS  = 14'(MAX_PAYLOAD_BYTES * 8 / N);
    localparam logic [13:0] MIN_LAST   = MIN_BEATS - 14'd1;
    localparam logic [6:0]  IFG_CYCLES = 7'(IFG_BITS / N);
    localparam logic [6:0]  IFG_LAST   = IFG_CYCLES - 7'd1;

    state_t          state, state_nxt;
    logic [2:0]      ptr;
    logic [2:0]      arb_idx;
    logic [NREQ-1:0] arb_oh, g_oh;
    logic [13:0]     beat_cnt, beat_nxt;
    logic [6:0]      ifg_cnt;
    logic            seen_busy;
    logic            g_valid, g_last, xfer, at_min, at_max;
    logic [N-1:0]    g_data;
    logic [47:0]     sel_mac;
    logic [15:0]     sel_etype;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (arb_oh),
        .idx (arb_idx)
    );

    assign beat_nxt = beat_cnt + 14'd1;
    assign xfer     = tx_valid && tx_ready;
    assign at_min   = beat_nxt >= MIN_BEATS;
    assign at_max   = beat_nxt == MAX_BEATS;

    // g_* follow the latched grant; sel_* follow the arbiter for latching at grant time.
    always_comb begin
        g_valid   = 1'b0;
        g_last    = 1'b0;
        g_data    = '0;
        sel_mac   = '0;
        sel_etype = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (g_oh[i]) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[i*N +: N];
            end
            if (arb_oh[i]) begin
                sel_mac   = req_dest_mac[i*48 +: 48];
                sel_etype = req_etype[i*16 +: 16];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = (|req_valid && !tx_busy) ? START : IDLE;
            START:     state_nxt = PAYLOAD;
            PAYLOAD:   if (xfer) state_nxt = g_last ? (at_min ? WAIT_DONE : PAD) : (at_max ? DRAIN : PAYLOAD);
            PAD:       if (xfer && beat_cnt == MIN_LAST) state_nxt = WAIT_DONE;
            DRAIN:     if (g_valid && g_last) state_nxt = WAIT_DONE;
            WAIT_DONE: if (seen_busy && !tx_busy) state_nxt = IFG;
            IFG:       if (ifg_cnt == IFG_LAST) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx_start  = state == START;
        tx_valid  = 1'b0;
        tx_data   = '0;
        tx_last   = 1'b0;
        trunc_err = 1'b0;
        req_ready = '0;
        case (state)
            PAYLOAD: begin
                tx_valid  = g_valid;
                tx_data   = g_data;
                tx_last   = g_valid && (g_last ? at_min : at_max);
                trunc_err = g_valid && tx_ready && !g_last && at_max;
                req_ready = g_oh & {NREQ{tx_ready}};
            end
            PAD: begin
                tx_valid = 1'b1;
                tx_last  = beat_cnt == MIN_LAST;
            end
            DRAIN:   req_ready = g_oh;
            default: ;
        endcase
    end

    // seen_busy is tracked for the whole frame: a truncated frame may finish
    // on the wire while its source is still being drained.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr         <= '0;
            grant_id    <= '0;
            g_oh        <= '0;
            tx_dest_mac <= '0;
            tx_etype    <= '0;
            beat_cnt    <= '0;
            ifg_cnt     <= '0;
            seen_busy   <= 1'b0;
            frames_sent <= '0;
        end else begin
            if (state == IDLE && state_nxt == START) begin
                grant_id    <= arb_idx;
                g_oh        <= arb_oh;
                tx_dest_mac <= sel_mac;
                tx_etype    <= sel_etype;
            end
            if (state == START) begin
                beat_cnt  <= '0;
                seen_busy <= 1'b0;
                ptr       <= (grant_id == 3'(NREQ - 1)) ? 3'd0 : grant_id + 3'd1;
            end else if (tx_busy) begin
                seen_busy <= 1'b1;
            end
            if ((state == PAYLOAD || state == PAD) && xfer) beat_cnt <= beat_nxt;
            if (state == WAIT_DONE && state_nxt == IFG) begin
                frames_sent <= frames_sent + 16'd1;
                ifg_cnt     <= '0;
            end
            if (state == IFG) ifg_cnt <= ifg_cnt + 7'd1;
        end
    end
endmodule
